crc_byte_engine: RTL and testbench
==================================

Name: crc_byte_engine

Overview:
- Sequential CRC core that sits directly downstream of the input bit_reversal stage in the CRC unit.
- Accepts one already-reordered data word (byte, half-word or word) per valid/ready handshake and folds it into a running CRC register, one byte per clock, MSB byte first.
- Supports programmable polynomial and CRC width (32/16/8/7).
- crc_out feeds the output bit_reversal stage.

Parameters:
- DATA_SIZE, 32, width of data_in, poly, crc_init and crc_out; fixed at 32 in this design.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- data_in  input  32  word from the input bit_reversal stage
- data_size  input  2  0=byte [7:0], 1=half [15:0], 2=word, 3=treated as word
- data_valid  input  1  data_in/data_size valid
- data_ready  output  1  engine can accept a word
- poly  input  32  polynomial, implicit top bit omitted, LSB-aligned
- poly_size  input  2  0=32-bit, 1=16-bit, 2=8-bit, 3=7-bit CRC
- crc_init  input  32  initial CRC value
- crc_init_load  input  1  single-cycle pulse: load crc_init
- crc_out  output  32  current CRC, LSB-aligned, bits above width are 0
- busy  output  1  high while bytes are being processed

Behaviour:
- Reset (rst_n low, asynchronous): crc_out=32'hFFFFFFFF, state IDLE, data_ready=1, busy=0, byte counter=0, latched poly/poly_size/data cleared.
- Width mask M: 0xFFFFFFFF, 0xFFFF, 0xFF, 0x7F for poly_size 0..3. Width W is 32/16/8/7.
- Per-byte step: 8 iterations, MSB of the byte first, non-reflected.
  - fb = crc[W-1] ^ d.
  - crc = (crc<<1) & M.
  - If fb, crc ^= poly & M.
- State IDLE:
  - data_ready=1, busy=0.
  - Handshake when data_valid & data_ready at a rising edge: latch data_in, poly, poly_size, and byte count n (1/2/4); go to PROC.
- State PROC:
  - data_ready=0, busy=1.
  - One byte per cycle, in order [8n-1:8n-8] down to [7:0].
  - crc_out updates after every byte.
  - After the n-th byte, return to IDLE.
  - Accept-to-final-crc_out latency: n cycles (byte: 1, half: 2, word: 4).
  - Back-to-back words: next accept at the earliest one cycle after the last byte. Throughput is n+1 cycles per word.
- crc_init_load:
  - Highest priority, in any state.
  - crc_out <= crc_init & M, where M comes from the live poly_size.
  - Aborts any word in progress and discards its remaining bytes. State becomes IDLE.
  - A data_valid in the same cycle is not accepted: data_ready is forced low during a crc_init_load cycle.
- poly, poly_size and data_in changes during PROC have no effect until the next accept.
- data_size=3 behaves exactly as data_size=2.
- Bits of crc_out above W are always 0 after any step or load.

Optional Feature:
- Macro: CRC_BYTE_ENGINE_SKID_EN.
- Defined:
  - One-entry skid buffer. data_ready stays high during PROC while the buffer is empty.
  - A word accepted during PROC is buffered and starts processing in the cycle after the current word's last byte, with no IDLE cycle.
  - Throughput is n cycles per word.
  - crc_init_load also flushes the buffer.
- Undefined: behaviour exactly as above (data_ready=0 throughout PROC).

Decomposition:
- Package crc_pkg:
  - data_size encodings (CRC_BYTE, CRC_HALF, CRC_WORD).
  - poly_size encodings (CRC_32, CRC_16, CRC_8, CRC_7).
  - Mask constants, the reset value 32'hFFFFFFFF, and a width-to-mask function.
- Sub-module crc_byte_step: purely combinational one-byte, 8-iteration LFSR update (crc, byte, poly, mask -> next crc). It is instantiated once in crc_byte_engine.
- crc_byte_engine holds the FSM, byte counter, latches and the optional skid buffer.

Test Plan:
- CRC-32/MPEG-2 word: reset; poly=0x04C11DB7, poly_size=0; one word 0x12345678 -> busy for 4 cycles; crc_out=0xDF8A8A2B; data_ready low during PROC (without SKID).
- CRC-16 mixed sizes: init 0xFFFF via crc_init_load; poly=0x1021, poly_size=1; words 0x31323334, 0x35363738, then byte 0x39 -> crc_out=0x29B1.
- CRC-8 and CRC-7: poly 0x07, init 0, same "123456789" stream -> 0xF4. Poly 0x09, poly_size=3, init 0 -> 0x75, with crc_out[31:7]=0.
- Abort: start word 0x12345678 (CRC-32); pulse crc_init_load=0xFFFFFFFF in the 2nd PROC cycle -> IDLE next cycle; crc_out=0xFFFFFFFF. Then re-sending the word -> 0xDF8A8A2B.
- Reset mid-operation: deassert rst_n during PROC -> crc_out=0xFFFFFFFF, data_ready=1, busy=0 immediately, with no clock edge needed.
- Back-to-back streaming: data_valid held high for 9 bytes of "123456789" as single bytes (CRC-32/MPEG-2) -> crc_out=0x0376E6E7. Cycle count: 18 without SKID, 9 with CRC_BYTE_ENGINE_SKID_EN.

Source files
------------

// File: rtl/crc_byte_engine_pkg.sv
// Shared encodings, masks and helpers for the byte-serial CRC engine.
package crc_pkg;

  typedef enum logic [1:0] {
    CRC_BYTE     = 2'd0,
    CRC_HALF     = 2'd1,
    CRC_WORD     = 2'd2,
    CRC_WORD_ALT = 2'd3
  } data_size_e;

  typedef enum logic [1:0] {
    CRC_32 = 2'd0,
    CRC_16 = 2'd1,
    CRC_8  = 2'd2,
    CRC_7  = 2'd3
  } poly_size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PROC = 1'b1
  } state_e;

  localparam logic [31:0] CRC_MASK_32   = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_MASK_16   = 32'h0000_FFFF;
  localparam logic [31:0] CRC_MASK_8    = 32'h0000_00FF;
  localparam logic [31:0] CRC_MASK_7    = 32'h0000_007F;
  localparam logic [31:0] CRC_RESET_VAL = 32'hFFFF_FFFF;

  // One accepted word: data, its polynomial context and the index of the
  // byte to be folded next (counts down to 0).
  typedef struct packed {
    logic [31:0] data;
    logic [31:0] poly;
    logic [1:0]  psize;
    logic [1:0]  idx;
  } word_t;

  function automatic logic [31:0] crc_width_mask(input logic [1:0] psize);
    logic [31:0] m;
    case (poly_size_e'(psize))
      CRC_32:  m = CRC_MASK_32;
      CRC_16:  m = CRC_MASK_16;
      CRC_8:   m = CRC_MASK_8;
      default: m = CRC_MASK_7;
    endcase
    return m;
  endfunction

  function automatic logic [1:0] first_byte_idx(input logic [1:0] dsize);
    logic [1:0] i;
    case (data_size_e'(dsize))
      CRC_BYTE: i = 2'd0;
      CRC_HALF: i = 2'd1;
      default:  i = 2'd3;
    endcase
    return i;
  endfunction

endpackage

// File: rtl/crc_byte_step.sv
// Combinational one-byte CRC update: eight non-reflected LFSR shifts, MSB first.
module crc_byte_step
  import crc_pkg::*;
#(
  parameter int DATA_SIZE = 32
) (
  input  logic [DATA_SIZE-1:0] crc,
  input  logic [7:0]           data_byte,
  input  logic [DATA_SIZE-1:0] poly,
  input  logic [DATA_SIZE-1:0] mask,
  output logic [DATA_SIZE-1:0] crc_next
);

  logic [DATA_SIZE-1:0] top_bit;
  logic [DATA_SIZE-1:0] work;
  logic                 fb;

  // The highest set bit of the contiguous mask marks the CRC's MSB.
  assign top_bit = mask ^ (mask >> 1);

  always_comb begin
    work = crc;
    fb   = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      fb   = (|(work & top_bit)) ^ data_byte[3'(i)];
      work = (work << 1) & mask;
      if (fb) begin
        work = work ^ (poly & mask);
      end
    end
    crc_next = work;
  end

endmodule

// File: rtl/crc_byte_engine.sv
// Byte-serial CRC engine: folds one 8/16/32-bit word per handshake, one byte per clock.
// Optional one-entry skid buffer enabled by defining CRC_BYTE_ENGINE_SKID_EN.
module crc_byte_engine
  import crc_pkg::*;
#(
  parameter int DATA_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic [1:0]           data_size,
  input  logic                 data_valid,
  output logic                 data_ready,
  input  logic [DATA_SIZE-1:0] poly,
  input  logic [1:0]           poly_size,
  input  logic [DATA_SIZE-1:0] crc_init,
  input  logic                 crc_init_load,
  output logic [DATA_SIZE-1:0] crc_out,
  output logic                 busy
);

  state_e      state_q, state_d;
  word_t       word_q;
  word_t       word_in;
  logic [31:0] crc_q;
  logic [31:0] crc_step;
  logic [31:0] mask_live;
  logic [31:0] mask_q;
  logic [7:0]  cur_byte;
  logic        last_byte;
  logic        accept;

`ifdef CRC_BYTE_ENGINE_SKID_EN
  word_t       skid_q;
  logic        skid_vld_q;
`endif

  assign word_in   = '{data: data_in, poly: poly, psize: poly_size,
                       idx: first_byte_idx(data_size)};
  assign mask_live = crc_width_mask(poly_size);
  assign mask_q    = crc_width_mask(word_q.psize);
  assign cur_byte  = word_q.data[{word_q.idx, 3'b000} +: 8];
  assign last_byte = (state_q == ST_PROC) && (word_q.idx == 2'd0);
  assign accept    = data_valid && data_ready;

  // A load cycle never accepts a word, whatever the state.
`ifdef CRC_BYTE_ENGINE_SKID_EN
  assign data_ready = !crc_init_load && ((state_q == ST_IDLE) || !skid_vld_q);
`else
  assign data_ready = !crc_init_load && (state_q == ST_IDLE);
`endif

  assign crc_out = crc_q;
  assign busy    = (state_q == ST_PROC);

  crc_byte_step #(
    .DATA_SIZE (32)
  ) u_step (
    .crc       (crc_q),
    .data_byte (cur_byte),
    .poly      (word_q.poly),
    .mask      (mask_q),
    .crc_next  (crc_step)
  );

  always_comb begin
    state_d = state_q;
    if (crc_init_load) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) state_d = ST_PROC;
        ST_PROC: begin
          if (last_byte) begin
`ifdef CRC_BYTE_ENGINE_SKID_EN
            state_d = (skid_vld_q || accept) ? ST_PROC : ST_IDLE;
`else
            state_d = ST_IDLE;
`endif
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      crc_q   <= CRC_RESET_VAL;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      if (crc_init_load) begin
        crc_q      <= crc_init & mask_live;
        word_q.idx <= 2'd0;
      end else begin
        if (state_q == ST_PROC) begin
          crc_q <= crc_step;
          if (word_q.idx != 2'd0) word_q.idx <= word_q.idx - 2'd1;
        end
`ifdef CRC_BYTE_ENGINE_SKID_EN
        // A fresh word goes straight to the working slot when it can start next cycle.
        if (accept && ((state_q == ST_IDLE) || (last_byte && !skid_vld_q))) begin
          word_q <= word_in;
        end else if (last_byte && skid_vld_q) begin
          word_q <= skid_q;
        end
`else
        if (accept) begin
          word_q <= word_in;
        end
`endif
      end
    end
  end

`ifdef CRC_BYTE_ENGINE_SKID_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else if (crc_init_load) begin
      skid_vld_q <= 1'b0;
    end else if (accept && (state_q == ST_PROC) && !last_byte) begin
      skid_q     <= word_in;
      skid_vld_q <= 1'b1;
    end else if (last_byte && skid_vld_q) begin
      skid_vld_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_crc_byte_engine.sv
// Self-checking bench for crc_byte_engine: known-answer table plus hand-written corner sequences.
module tb_crc_byte_engine;

`ifdef CRC_BYTE_ENGINE_SKID_EN
  localparam int   PER      = 1;
  localparam logic PROC_RDY = 1'b1;
`else
  localparam int   PER      = 2;
  localparam logic PROC_RDY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data_in;
  logic [1:0]  data_size;
  logic        data_valid;
  logic        data_ready;
  logic [31:0] poly;
  logic [1:0]  poly_size;
  logic [31:0] crc_init;
  logic        crc_init_load;
  logic [31:0] crc_out;
  logic        busy;

  crc_byte_engine #(.DATA_SIZE(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_in       (data_in),
    .data_size     (data_size),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .poly          (poly),
    .poly_size     (poly_size),
    .crc_init      (crc_init),
    .crc_init_load (crc_init_load),
    .crc_out       (crc_out),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] crc;
    int          due;
  } sb_t;
  sb_t sb[$];
  sb_t sb_e;

  logic [31:0] mcrc;
  int          first_acc;
  int          last_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_mask(input logic [1:0] ps);
    int w;
    logic [31:0] m;
    w = (ps == 2'd0) ? 32 : (ps == 2'd1) ? 16 : (ps == 2'd2) ? 8 : 7;
    m = '0;
    for (int b = 0; b < w; b++) m[b] = 1'b1;
    return m;
  endfunction

  // Bit-serial reference, written per bit position rather than with masks.
  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [31:0] d,
                                          input int nb, input logic [31:0] p,
                                          input logic [1:0] ps);
    int w;
    logic [31:0] r;
    logic msb;
    w = (ps == 2'd0) ? 32 : (ps == 2'd1) ? 16 : (ps == 2'd2) ? 8 : 7;
    r = c;
    for (int i = 8 * nb - 1; i >= 0; i--) begin
      msb = r[w-1] ^ d[i];
      r = r << 1;
      for (int b = w; b < 32; b++) r[b] = 1'b0;
      if (msb) for (int b = 0; b < w; b++) r[b] = r[b] ^ p[b];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      sb_e = sb.pop_front();
      check("sb_crc", crc_out, sb_e.crc);
    end
  end

  // Called just after a rising edge; leaves data_valid high for back-to-back use.
  task automatic send(input logic [31:0] d, input logic [1:0] ds);
    int waited;
    int nb;
    waited = 0;
    data_in = d; data_size = ds; data_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (data_ready) break;
      waited++;
      if (waited > 50) begin
        checks++; errors++;
        $display("FAIL send_timeout: data_ready stayed %b, required 1", data_ready);
        data_valid = 1'b0;
        @(posedge clk); #1;
        return;
      end
    end
    @(posedge clk); #1;
    nb = (ds == 2'd0) ? 1 : (ds == 2'd1) ? 2 : 4;
    if (first_acc < 0) first_acc = cyc;
    last_acc = cyc;
    mcrc = ref_crc(mcrc, d, nb, poly, poly_size);
    sb.push_back('{crc: mcrc, due: cyc + nb});
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_load(input logic [31:0] v);
    crc_init = v; crc_init_load = 1'b1;
    @(posedge clk); #1;
    crc_init_load = 1'b0;
    sb.delete();
    mcrc = v & ref_mask(poly_size);
  endtask

  // "123456789" packed four different ways; junk above the used bits.
  task automatic send_stream(input int mode);
    case (mode)
      0: for (int i = 0; i < 9; i++) send({24'hA5C35A, 8'(8'h31 + i)}, 2'd0);
      1: begin
        send(32'h31323334, 2'd2); send(32'h35363738, 2'd2); send(32'hDEADBE39, 2'd0);
      end
      2: begin
        send(32'hFFFF3132, 2'd1); send(32'h12343334, 2'd1);
        send(32'h00003536, 2'd1); send(32'hABCD3738, 2'd1); send(32'h77777739, 2'd0);
      end
      default: begin
        send(32'h31323334, 2'd3); send(32'h35363738, 2'd3); send(32'h00000039, 2'd0);
      end
    endcase
    data_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] poly;
    logic [1:0]  psize;
    logic [31:0] init;
    int          mode;
    logic [31:0] expect_crc;
  } vec_t;
  vec_t vecs[8];

  int busy_cnt;
  int rdy_bad;

  initial begin
    vecs[0] = '{32'h04C11DB7, 2'd0, 32'hFFFFFFFF, 1, 32'h0376E6E7};
    vecs[1] = '{32'h00001021, 2'd1, 32'hABCDFFFF, 1, 32'h000029B1};
    vecs[2] = '{32'h00000007, 2'd2, 32'h00000000, 2, 32'h000000F4};
    vecs[3] = '{32'h00000009, 2'd3, 32'hFFFFFF00, 0, 32'h00000075};
    vecs[4] = '{32'h00001021, 2'd1, 32'h00000000, 3, 32'h000031C3};
    vecs[5] = '{32'h0000009B, 2'd2, 32'h123456FF, 0, 32'h000000DA};
    vecs[6] = '{32'h04C11DB7, 2'd0, 32'hFFFFFFFF, 2, 32'h0376E6E7};
    vecs[7] = '{32'hFFFFFF09, 2'd3, 32'h00000000, 3, 32'h00000075};

    rst_n = 1'b0; data_in = '0; data_size = '0; data_valid = 1'b0;
    poly = 32'h04C11DB7; poly_size = 2'd0; crc_init = '0; crc_init_load = 1'b0;
    mcrc = 32'hFFFFFFFF; first_acc = -1; last_acc = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_crc", crc_out, 32'hFFFFFFFF);
    check("reset_ready", 32'(data_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // CRC-32/MPEG-2 single word: latency, busy window, ready during PROC.
    send(32'h12345678, 2'd2);
    data_valid = 1'b0;
    poly = 32'hDEADBEEF; poly_size = 2'd2;
    busy_cnt = 0; rdy_bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy) begin
        busy_cnt++;
        if (data_ready !== PROC_RDY) rdy_bad++;
      end
    end
    check("word_busy_cycles", 32'(busy_cnt), 32'd4);
    check("word_ready_in_proc", 32'(rdy_bad), 32'd0);
    check("word_crc32", crc_out, 32'hDF8A8A2B);
    @(posedge clk); #1;
    poly = 32'h04C11DB7; poly_size = 2'd0;

    // Known-answer table over four ways of packing the same stream.
    for (int v = 0; v < 8; v++) begin
      drain();
      poly = vecs[v].poly; poly_size = vecs[v].psize;
      do_load(vecs[v].init);
      @(negedge clk);
      check($sformatf("load_%0d", v), crc_out, vecs[v].init & ref_mask(vecs[v].psize));
      @(posedge clk); #1;
      send_stream(vecs[v].mode);
      drain();
      check($sformatf("vec_%0d", v), crc_out, vecs[v].expect_crc);
    end

    // Abort: load in the second PROC cycle discards the word.
    poly = 32'h04C11DB7; poly_size = 2'd0;
    do_load(32'hFFFFFFFF);
    send(32'h12345678, 2'd2);
    data_valid = 1'b0;
    @(posedge clk); #1;
    crc_init = 32'hFFFFFFFF; crc_init_load = 1'b1;
    sb.delete();
    @(negedge clk);
    check("abort_ready_low", 32'(data_ready), 32'd0);
    @(posedge clk); #1;
    crc_init_load = 1'b0;
    mcrc = 32'hFFFFFFFF;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_crc", crc_out, 32'hFFFFFFFF);
    @(posedge clk); #1;
    send(32'h12345678, 2'd2);
    data_valid = 1'b0;
    drain();
    check("abort_resend_crc", crc_out, 32'hDF8A8A2B);

    // Load in IDLE with data_valid high: word must not be taken.
    crc_init = 32'h89ABCDEF; crc_init_load = 1'b1;
    data_in = 32'h55555555; data_size = 2'd2; data_valid = 1'b1;
    @(negedge clk);
    check("load_blocks_ready", 32'(data_ready), 32'd0);
    @(posedge clk); #1;
    crc_init_load = 1'b0; data_valid = 1'b0;
    mcrc = 32'h89ABCDEF;
    @(negedge clk);
    check("load_no_accept_busy", 32'(busy), 32'd0);
    check("load_idle_crc", crc_out, 32'h89ABCDEF);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send($urandom, 2'(i));
    data_valid = 1'b0;
    drain();

    // Asynchronous reset in the middle of a word.
    send(32'hCAFEF00D, 2'd2);
    data_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("areset_crc", crc_out, 32'hFFFFFFFF);
    check("areset_ready", 32'(data_ready), 32'd1);
    check("areset_busy", 32'(busy), 32'd0);
    sb.delete();
    mcrc = 32'hFFFFFFFF;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back single bytes with data_valid held high.
    poly = 32'h04C11DB7; poly_size = 2'd0;
    first_acc = -1;
    send_stream(0);
    drain();
    check("stream_crc", crc_out, 32'h0376E6E7);
    check("stream_cycles", 32'(last_acc - first_acc + PER), 32'(9 * PER));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

endmodule
